pong_match_ctrl: RTL and testbench
==================================

PONG_MATCH_CTRL -- requirements
Module: pong_match_ctrl

Interface
REQ-001 Parameter WIN_SCORE, default 5: points needed to win a match; legal range 1..15.
REQ-002 Parameter SERVE_FRAMES, default 60: number of frames the ball is held centred before each serve; legal range 1..255.
REQ-003 Parameter OVER_FRAMES, default 180: number of frames the game-over screen is shown before the block returns to IDLE; legal range 1..255.
REQ-004 Parameter DEB_FRAMES, default 3: number of consecutive frame samples needed to debounce start_btn; legal range 1..15.
REQ-005 clk  in  1  single clock; every register updates on its rising edge.
REQ-006 reset_n  in  1  reset, synchronous and active-low.
REQ-007 endframe  in  1  one-clk pulse per video frame, synchronous to clk.
REQ-008 start_btn  in  1  raw start/pause button, active-high.
REQ-009 goal_left  in  1  one-clk pulse: ball left via the left edge; player 2 scores.
REQ-010 goal_right  in  1  one-clk pulse: ball left via the right edge; player 1 scores.
REQ-011 game_reset  out  1  active-high reset to the game datapath (re-centres the ball).
REQ-012 play  out  1  high enables ball motion in the game datapath.
REQ-013 serve_dir  out  1  0 = serve toward player 1, 1 = serve toward player 2.
REQ-014 score1, score2  out  4 each  player scores.
REQ-015 winner  out  2  0 = none, 1 = player 1, 2 = player 2.
REQ-016 state  out  3  state code: IDLE=0, SERVE=1, PLAY=2, PAUSE=3, OVER=4.

Function
REQ-017 All outputs SHALL be registered; each output SHALL reflect the state entered at the same clk edge that makes the transition.
REQ-018 Debounce: on each endframe pulse the block SHALL sample start_btn; a debounced level SHALL go high after DEB_FRAMES consecutive high samples and low after one low sample.
REQ-019 A press SHALL be an internal one-clk strobe on the rising edge of the debounced level; a held button SHALL produce exactly one press.
REQ-020 frame_cnt, 8 bits, SHALL clear on every state entry and SHALL increment on endframe otherwise; an endframe in the entry cycle SHALL NOT be counted.
REQ-021 IDLE: game_reset=1, play=0. A press SHALL clear both scores, set winner=0 and serve_dir=1, and go to SERVE.
REQ-022 SERVE: game_reset=1, play=0. The block SHALL go to PLAY on the endframe that makes frame_cnt reach SERVE_FRAMES. Presses SHALL be ignored in SERVE.
REQ-023 PLAY: game_reset=0, play=1.
REQ-024 PLAY, goal_right alone: score1 SHALL increment and serve_dir SHALL become 1, toward the conceding player.
REQ-025 PLAY, goal_left alone: score2 SHALL increment and serve_dir SHALL become 0.
REQ-026 After a goal, the next state SHALL be OVER if the new score equals WIN_SCORE, otherwise SERVE.
REQ-027 PLAY: goal_left and goal_right in the same cycle SHALL both be ignored; the block SHALL stay in PLAY.
REQ-028 PLAY: a press with no goal SHALL go to PAUSE. If a press and a goal coincide, the goal SHALL take priority and the press SHALL be dropped.
REQ-029 PAUSE: game_reset=0, play=0 (ball frozen in place). Goals SHALL be ignored; a press SHALL return the block to PLAY.
REQ-030 OVER: game_reset=0, play=0. winner SHALL be set on entry and held; scores SHALL be held.
REQ-031 OVER: a press SHALL start a new match exactly as REQ-021 does. Otherwise the block SHALL go to IDLE when frame_cnt reaches OVER_FRAMES, with scores and winner held until the next press.
REQ-032 Goal pulses in IDLE, SERVE, PAUSE and OVER SHALL have no effect.
REQ-033 Scores SHALL never exceed WIN_SCORE, since the block leaves PLAY when a score reaches it.
REQ-034 Unused state codes SHALL go to IDLE on the next clk edge.

Reset
REQ-035 reset_n=0 at a clk edge SHALL force, at that edge and regardless of current state: state=IDLE, game_reset=1, play=0, score1=score2=0, winner=0, serve_dir=1, frame_cnt=0, debounce counter=0, debounced level=0.
REQ-036 When reset_n is asserted mid-match, any goal or press in the same cycle SHALL be discarded.

Verification (DEB_FRAMES=3, SERVE_FRAMES=60, WIN_SCORE=5, OVER_FRAMES=180)
REQ-037 Reset, then start_btn held high for 3 endframes -> one press; state 0 to 1, game_reset=1; after 60 further endframes, state=2, play=1, game_reset=0.
REQ-038 Bounce test: start_btn high 2 frames, low 1 frame, high 2 frames -> no press, state stays 0. Button then held 10 frames -> exactly one press.
REQ-039 In PLAY, goal_right pulse -> score1=1, serve_dir=1, state=1. goal_left and goal_right together -> scores unchanged, state stays 2.
REQ-040 In PLAY, press -> state=3, play=0, game_reset=0. goal_left during PAUSE -> score2 unchanged. Second press -> state=2.
REQ-041 Score 4-0, then goal_right -> score1=5, winner=1, state=4. After 180 endframes -> state=0 with score1=5 held. Press -> scores 0, winner 0, state=1.
REQ-042 reset_n=0 in PLAY at score 3-2, coinciding with a goal_left pulse -> next edge gives state=0, score1=score2=0, play=0, game_reset=1.

Source files
------------

// File: rtl/pong_match_ctrl.sv
// Match controller for a two-player pong game.
//
// Debounces the start/pause button on frame boundaries and sequences a match
// through IDLE -> SERVE -> PLAY (<-> PAUSE) -> OVER. It keeps both scores and
// the serve direction, and drives the game datapath's reset and motion enable.
//
// Ports:
//   clk        in   single clock, rising edge
//   reset_n    in   synchronous active-low reset
//   endframe   in   one-clk pulse per video frame
//   start_btn  in   raw start/pause button, active-high
//   goal_left  in   ball left via the left edge (player 2 scores)
//   goal_right in   ball left via the right edge (player 1 scores)
//   game_reset out  re-centres the ball in the datapath
//   play       out  enables ball motion
//   serve_dir  out  0 = serve toward player 1, 1 = toward player 2
//   score1/2   out  player scores
//   winner     out  0 = none, 1 = player 1, 2 = player 2
//   state      out  IDLE=0, SERVE=1, PLAY=2, PAUSE=3, OVER=4
module pong_match_ctrl #(
  parameter int unsigned WIN_SCORE    = 5,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned OVER_FRAMES  = 180,
  parameter int unsigned DEB_FRAMES   = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       endframe,
  input  logic       start_btn,
  input  logic       goal_left,
  input  logic       goal_right,
  output logic       game_reset,
  output logic       play,
  output logic       serve_dir,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [1:0] winner,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StServe = 3'd1,
    StPlay  = 3'd2,
    StPause = 3'd3,
    StOver  = 3'd4
  } state_e;

  localparam logic [3:0] DebMax    = 4'(DEB_FRAMES);
  localparam logic [3:0] WinScore  = 4'(WIN_SCORE);
  // Compare against N-1 so the endframe that brings the count to N fires the exit.
  localparam logic [7:0] ServeLast = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] OverLast  = 8'(OVER_FRAMES - 1);

  state_e     st_q, st_d;
  logic [3:0] deb_cnt_q, deb_cnt_d;
  logic       deb_lvl_q, deb_lvl_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [3:0] score1_q, score1_d, score2_q, score2_d;
  logic [1:0] winner_q, winner_d;
  logic       serve_dir_q, serve_dir_d;
  logic       game_reset_q, game_reset_d;
  logic       play_q, play_d;
  logic       press;
  logic [3:0] s1_inc, s2_inc;

  // Debounce: count consecutive high samples, drop on the first low one.
  always_comb begin
    deb_cnt_d = deb_cnt_q;
    deb_lvl_d = deb_lvl_q;
    if (endframe) begin
      if (start_btn) begin
        if (deb_cnt_q < DebMax) deb_cnt_d = deb_cnt_q + 4'd1;
        if (deb_cnt_q >= DebMax - 4'd1) deb_lvl_d = 1'b1;
      end else begin
        deb_cnt_d = 4'd0;
        deb_lvl_d = 1'b0;
      end
    end
  end

  // One strobe per rising edge of the debounced level; a held button stays high.
  assign press  = deb_lvl_d & ~deb_lvl_q;
  assign s1_inc = score1_q + 4'd1;
  assign s2_inc = score2_q + 4'd1;

  always_comb begin
    st_d        = st_q;
    score1_d    = score1_q;
    score2_d    = score2_q;
    winner_d    = winner_q;
    serve_dir_d = serve_dir_q;
    unique case (st_q)
      StIdle: begin
        if (press) begin
          st_d        = StServe;
          score1_d    = 4'd0;
          score2_d    = 4'd0;
          winner_d    = 2'd0;
          serve_dir_d = 1'b1;
        end
      end
      StServe: begin
        if (endframe && frame_cnt_q == ServeLast) st_d = StPlay;
      end
      StPlay: begin
        if (goal_right && !goal_left) begin
          score1_d    = s1_inc;
          serve_dir_d = 1'b1;
          if (s1_inc == WinScore) begin
            st_d     = StOver;
            winner_d = 2'd1;
          end else begin
            st_d = StServe;
          end
        end else if (goal_left && !goal_right) begin
          score2_d    = s2_inc;
          serve_dir_d = 1'b0;
          if (s2_inc == WinScore) begin
            st_d     = StOver;
            winner_d = 2'd2;
          end else begin
            st_d = StServe;
          end
        end else if (press && !goal_left && !goal_right) begin
          // Any goal pulse, even a cancelled simultaneous pair, drops the press.
          st_d = StPause;
        end
      end
      StPause: begin
        if (press) st_d = StPlay;
      end
      StOver: begin
        if (press) begin
          st_d        = StServe;
          score1_d    = 4'd0;
          score2_d    = 4'd0;
          winner_d    = 2'd0;
          serve_dir_d = 1'b1;
        end else if (endframe && frame_cnt_q == OverLast) begin
          st_d = StIdle;
        end
      end
      default: st_d = StIdle;
    endcase

    // Clear on state entry so the entry-cycle endframe is not counted.
    if (st_d != st_q)  frame_cnt_d = 8'd0;
    else if (endframe) frame_cnt_d = frame_cnt_q + 8'd1;
    else               frame_cnt_d = frame_cnt_q;

    game_reset_d = (st_d == StIdle) || (st_d == StServe);
    play_d       = (st_d == StPlay);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st_q         <= StIdle;
      deb_cnt_q    <= 4'd0;
      deb_lvl_q    <= 1'b0;
      frame_cnt_q  <= 8'd0;
      score1_q     <= 4'd0;
      score2_q     <= 4'd0;
      winner_q     <= 2'd0;
      serve_dir_q  <= 1'b1;
      game_reset_q <= 1'b1;
      play_q       <= 1'b0;
    end else begin
      st_q         <= st_d;
      deb_cnt_q    <= deb_cnt_d;
      deb_lvl_q    <= deb_lvl_d;
      frame_cnt_q  <= frame_cnt_d;
      score1_q     <= score1_d;
      score2_q     <= score2_d;
      winner_q     <= winner_d;
      serve_dir_q  <= serve_dir_d;
      game_reset_q <= game_reset_d;
      play_q       <= play_d;
    end
  end

  assign state      = st_q;
  assign game_reset = game_reset_q;
  assign play       = play_q;
  assign serve_dir  = serve_dir_q;
  assign score1     = score1_q;
  assign score2     = score2_q;
  assign winner     = winner_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
module tb_pong_match_ctrl;

  logic       clk = 1'b0;
  logic       reset_n, endframe, start_btn, goal_left, goal_right;
  logic       game_reset, play, serve_dir;
  logic [3:0] score1, score2;
  logic [1:0] winner;
  logic [2:0] state;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pong_match_ctrl #(
    .WIN_SCORE   (5),
    .SERVE_FRAMES(60),
    .OVER_FRAMES (180),
    .DEB_FRAMES  (3)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .endframe  (endframe),
    .start_btn (start_btn),
    .goal_left (goal_left),
    .goal_right(goal_right),
    .game_reset(game_reset),
    .play      (play),
    .serve_dir (serve_dir),
    .score1    (score1),
    .score2    (score2),
    .winner    (winner),
    .state     (state)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One frame: endframe pulse with the given button level, then a quiet cycle.
  task automatic frame(input logic btn);
    start_btn = btn;
    endframe  = 1'b1;
    cyc();
    endframe = 1'b0;
    cyc();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame(1'b0);
  endtask

  // Three high samples make the press, one low sample releases it.
  task automatic press_btn();
    for (int i = 0; i < 3; i++) frame(1'b1);
    frame(1'b0);
  endtask

  task automatic goal(input logic l, input logic r);
    goal_left  = l;
    goal_right = r;
    cyc();
    goal_left  = 1'b0;
    goal_right = 1'b0;
  endtask

  // Serve with no frames counted yet: 60 endframes reach PLAY.
  task automatic serve_wait();
    frames(60);
  endtask

  initial begin
    reset_n = 1'b0; endframe = 1'b0; start_btn = 1'b0;
    goal_left = 1'b0; goal_right = 1'b0;
    repeat (3) cyc();
    chk("rst_state", state, 0);
    chk("rst_game_reset", game_reset, 1);
    chk("rst_play", play, 0);
    chk("rst_score1", score1, 0);
    chk("rst_score2", score2, 0);
    chk("rst_winner", winner, 0);
    chk("rst_serve_dir", serve_dir, 1);
    reset_n = 1'b1;
    cyc();

    // Bounce: 2 high, 1 low, 2 high -> no press.
    frame(1'b1); frame(1'b1); frame(1'b0); frame(1'b1); frame(1'b1);
    chk("bounce_idle", state, 0);
    frame(1'b1);
    chk("press_serve", state, 1);
    chk("serve_game_reset", game_reset, 1);
    chk("serve_play", play, 0);
    frame(1'b0);
    frames(58);
    chk("serve_59", state, 1);
    goal(1'b0, 1'b1);
    chk("serve_goal_ignored", score1, 0);
    frames(1);
    chk("play_state", state, 2);
    chk("play_play", play, 1);
    chk("play_game_reset", game_reset, 0);

    goal(1'b0, 1'b1);
    chk("gr_score1", score1, 1);
    chk("gr_serve_dir", serve_dir, 1);
    chk("gr_state", state, 1);
    serve_wait();
    chk("back_play", state, 2);
    goal(1'b1, 1'b1);
    chk("both_state", state, 2);
    chk("both_s1", score1, 1);
    chk("both_s2", score2, 0);
    goal(1'b1, 1'b0);
    chk("gl_score2", score2, 1);
    chk("gl_serve_dir", serve_dir, 0);
    chk("gl_state", state, 1);
    serve_wait();

    // Held button in PLAY: exactly one press -> PAUSE (a second would resume).
    for (int i = 0; i < 10; i++) frame(1'b1);
    frame(1'b0);
    chk("pause_state", state, 3);
    chk("pause_play", play, 0);
    chk("pause_game_reset", game_reset, 0);
    goal(1'b1, 1'b0);
    chk("pause_goal_s2", score2, 1);
    chk("pause_goal_state", state, 3);
    press_btn();
    chk("resume_state", state, 2);

    // Reach 3-2.
    goal(1'b0, 1'b1); serve_wait();
    goal(1'b0, 1'b1); serve_wait();
    goal(1'b1, 1'b0); serve_wait();
    chk("s32_s1", score1, 3);
    chk("s32_s2", score2, 2);
    chk("s32_state", state, 2);

    // Reset mid-match with a coincident goal.
    reset_n   = 1'b0;
    goal_left = 1'b1;
    cyc();
    goal_left = 1'b0;
    reset_n   = 1'b1;
    chk("mid_rst_state", state, 0);
    chk("mid_rst_s1", score1, 0);
    chk("mid_rst_s2", score2, 0);
    chk("mid_rst_play", play, 0);
    chk("mid_rst_game_reset", game_reset, 1);

    // New match to 5-0.
    press_btn();
    frames(59);
    chk("m2_play", state, 2);
    for (int i = 0; i < 4; i++) begin
      goal(1'b0, 1'b1);
      serve_wait();
    end
    chk("s40_s1", score1, 4);
    goal(1'b0, 1'b1);
    chk("win_s1", score1, 5);
    chk("win_winner", winner, 1);
    chk("win_state", state, 4);
    chk("over_play", play, 0);
    chk("over_game_reset", game_reset, 0);
    frames(179);
    chk("over_179", state, 4);
    frames(1);
    chk("over_idle", state, 0);
    chk("idle_s1_held", score1, 5);
    chk("idle_winner_held", winner, 1);
    for (int i = 0; i < 3; i++) frame(1'b1);
    chk("new_state", state, 1);
    chk("new_s1", score1, 0);
    chk("new_s2", score2, 0);
    chk("new_winner", winner, 0);
    chk("new_serve_dir", serve_dir, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
